cpuid_walker: RTL and testbench

CPUID_WALKER -- requirements
Module: cpuid_walker

---
 rtl/cpuid_walker.sv | 177 +++++++++++++++++
 tb/tb_cpuid_walker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpuid_walker.sv
// cpuid_walker: walks CPUID standard leaves 0..max_leaf, issuing one query
// per leaf, capturing the four 32-bit result words and streaming them out
// one word per handshake. Leaf 0 word 0 supplies the walk limit, clamped
// to MAX_LEAF_CAP. A response that never arrives aborts the walk with
// err_timeout after TIMEOUT_CYCLES cycles in WAIT.
//
// Handshakes (req_* and out_*): valid/ready. A transfer happens on the
// rising clk edge where valid && ready are both high. Once valid rises,
// valid and its payload hold steady until that transfer; ready may toggle
// freely and never feeds back combinationally into valid or payload.
module cpuid_walker #(
    parameter int MAX_LEAF_CAP   = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic [15:0] max_leaf,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_leaf,
    output logic [31:0] req_subleaf,
    input  logic        rsp_valid,
    input  logic [63:0] rsp_data0,
    input  logic [63:0] rsp_data1,
    input  logic [63:0] rsp_data2,
    input  logic [63:0] rsp_data3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_leaf,
    output logic [1:0]  out_idx,
    output logic [31:0] out_word,
    output logic [2:0]  dbg_state
);

    // Timer only has to reach TIMEOUT_CYCLES; it leaves WAIT there, so it never wraps.
    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES);
    localparam logic [15:0]   LEAF_CAP   = 16'(MAX_LEAF_CAP);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   cur_leaf;
    logic [15:0]   max_leaf_q;
    logic          err_q;
    logic [TW-1:0] timer;
    logic [1:0]    idx;
    logic [31:0]   w [4];

    logic [15:0]   clamp_max;
    logic [15:0]   eff_max;
    logic          timer_hit;
    logic          emit_last;
    logic          walk_end;
    logic          unused_rsp_hi;

    // Only the low halves of the response words carry CPUID data.
    assign unused_rsp_hi = ^{rsp_data0[63:32], rsp_data1[63:32],
                             rsp_data2[63:32], rsp_data3[63:32]};

    // Walk-limit arithmetic: clamp leaf 0's report, and use the freshly
    // clamped value when deciding whether leaf 0 itself is the last leaf.
    always_comb begin
        clamp_max = (w[0][15:0] > LEAF_CAP) ? LEAF_CAP : w[0][15:0];
        eff_max   = (cur_leaf == 16'd0) ? clamp_max : max_leaf_q;
        timer_hit = (timer == TIMER_LAST);
        emit_last = out_ready && (idx == 2'd3);
        walk_end  = (cur_leaf >= eff_max);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a response beats a timeout on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ:  if (req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (rsp_valid) begin
                    state_nxt = S_EMIT;
                end else if (timer_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_EMIT: if (emit_last) state_nxt = walk_end ? S_DONE : S_REQ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Walk datapath: leaf counter, limit, sticky error, timer, word buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_leaf   <= '0;
            max_leaf_q <= '0;
            err_q      <= 1'b0;
            timer      <= '0;
            idx        <= '0;
            w[0]       <= '0;
            w[1]       <= '0;
            w[2]       <= '0;
            w[3]       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_leaf   <= '0;
                        max_leaf_q <= '0;
                        err_q      <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (req_ready) timer <= '0;
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        w[0] <= rsp_data0[31:0];
                        w[1] <= rsp_data1[31:0];
                        w[2] <= rsp_data2[31:0];
                        w[3] <= rsp_data3[31:0];
                        idx  <= '0;
                    end else if (timer_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        idx <= idx + 1'b1;
                        if (idx == 2'd3) begin
                            if (cur_leaf == 16'd0) max_leaf_q <= clamp_max;
                            if (!walk_end) cur_leaf <= cur_leaf + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and registers only.
    always_comb begin
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        err_timeout = err_q;
        max_leaf    = max_leaf_q;
        req_valid   = (state == S_REQ);
        req_leaf    = (state == S_REQ) ? {16'd0, cur_leaf} : 32'd0;
        req_subleaf = 32'd0;
        out_valid   = (state == S_EMIT);
        out_leaf    = (state == S_EMIT) ? cur_leaf : 16'd0;
        out_idx     = (state == S_EMIT) ? idx : 2'd0;
        out_word    = (state == S_EMIT) ? w[idx] : 32'd0;
        dbg_state   = state;
    end

endmodule

// File: tb/tb_cpuid_walker.sv
// Bench for cpuid_walker: random-latency CPUID responder, random
// backpressure, and a reference model that lists every expected
// (leaf, idx, word) of a walk up front from the walk rules.
module tb_cpuid_walker;

    localparam int CAP = 16;
    localparam int TMO = 255;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [63:0] rsp_data0 = '0, rsp_data1 = '0, rsp_data2 = '0, rsp_data3 = '0;
    logic        out_ready = 1'b0;
    logic        busy, done, err_timeout, req_valid, out_valid;
    logic [15:0] max_leaf, out_leaf;
    logic [31:0] req_leaf, req_subleaf, out_word;
    logic [1:0]  out_idx;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    cpuid_walker #(.MAX_LEAF_CAP(CAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err_timeout(err_timeout), .max_leaf(max_leaf),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_leaf(req_leaf), .req_subleaf(req_subleaf),
        .rsp_valid(rsp_valid), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rsp_data2(rsp_data2), .rsp_data3(rsp_data3),
        .out_valid(out_valid), .out_ready(out_ready), .out_leaf(out_leaf),
        .out_idx(out_idx), .out_word(out_word), .dbg_state(dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- test configuration ----------------
    logic [31:0] cfg_word0 = 32'h5;
    logic [31:0] cfg_seed = 32'h1234_5678;
    int cfg_lat_min = 0, cfg_lat_max = 0;
    bit cfg_rand_ready = 0, cfg_junk = 0, cfg_rand_start = 0;
    int cfg_silent = -1, cfg_slow_leaf = -1;
    bit kick = 0;

    // Responder contents: leaf 0 word 0 is the reported limit, leaf 4 is all zero.
    function automatic logic [31:0] leaf_word(input int leaf, input int i);
        logic [31:0] l32, i32;
        if (leaf == 0 && i == 0) return cfg_word0;
        if (leaf == 4) return 32'd0;
        l32 = 32'(leaf);
        i32 = 32'(i);
        return (l32 * 32'h9E37_79B9) ^ ((i32 + 32'd1) * 32'h85EB_CA6B) ^ cfg_seed;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [49:0] exp_q[$];
    int          words = 0;
    int          done_cnt = 0;
    int          done_edge = 0;
    int          hs_edge_silent = -1;
    logic [15:0] last_out_leaf = '1;
    bit          hs_req = 0;
    int          hs_leaf = 0;
    bit          stall_pend = 0;
    logic [50:0] stall_snap = '0;
    bit          req_pend = 0;
    logic [31:0] req_snap = '0;

    always @(negedge clk) begin
        logic [49:0] e;
        if (!rst_n) begin
            stall_pend = 0;
            req_pend   = 0;
        end else begin
            if (req_pend) check("req_hold", {req_valid, req_leaf}, {1'b1, req_snap});
            req_pend = req_valid && !req_ready;
            req_snap = req_leaf;
            if (req_valid && req_ready) begin
                hs_req  = 1;
                hs_leaf = int'(req_leaf);
                check("req_subleaf", req_subleaf, 0);
                if (int'(req_leaf) == cfg_silent) hs_edge_silent = cyc + 1;
            end
            if (done) begin
                done_cnt++;
                done_edge = cyc;
            end
            if (stall_pend) check("out_hold", {out_valid, out_leaf, out_idx, out_word}, stall_snap);
            stall_pend = out_valid && !out_ready;
            stall_snap = {out_valid, out_leaf, out_idx, out_word};
            if (out_valid && out_ready) begin
                words++;
                last_out_leaf = out_leaf;
                if (exp_q.size() == 0) begin
                    check("extra_word", {out_leaf, out_idx, out_word}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {out_leaf, out_idx, out_word}, e);
                end
            end
        end
    end

    // ---------------- driver: responder, ready, start ----------------
    initial begin
        bit pend;
        int pend_leaf, pend_cnt;
        pend = 0; pend_leaf = 0; pend_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 0; hs_req = 0; req_ready = 1'b0; start = 1'b0;
                continue;
            end
            req_ready = cfg_rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready = cfg_rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (hs_req) begin
                hs_req = 0;
                if (hs_leaf != cfg_silent) begin
                    pend      = 1;
                    pend_leaf = hs_leaf;
                    pend_cnt  = (hs_leaf == cfg_slow_leaf) ? TMO
                                                           : $urandom_range(cfg_lat_min, cfg_lat_max);
                end
            end
            if (pend) begin
                if (pend_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data0 = {$urandom(), leaf_word(pend_leaf, 0)};
                    rsp_data1 = {$urandom(), leaf_word(pend_leaf, 1)};
                    rsp_data2 = {$urandom(), leaf_word(pend_leaf, 2)};
                    rsp_data3 = {$urandom(), leaf_word(pend_leaf, 3)};
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end else if (cfg_junk && (req_valid || !busy) && ($urandom_range(0, 1) == 1)) begin
                rsp_valid = 1'b1;
                rsp_data0 = {$urandom(), $urandom()};
                rsp_data1 = {$urandom(), $urandom()};
                rsp_data2 = {$urandom(), $urandom()};
                rsp_data3 = {$urandom(), $urandom()};
            end
            if (kick) begin
                start = 1'b1;
                kick  = 0;
            end else if (cfg_rand_start && busy) begin
                start = done || ($urandom_range(0, 3) == 0);
            end else begin
                start = 1'b0;
            end
        end
    end

    task automatic set_cfg(input logic [31:0] w0, input int lmin, input int lmax, input bit rr,
                           input int silent, input int slow, input bit junk, input bit rs);
        cfg_word0 = w0; cfg_lat_min = lmin; cfg_lat_max = lmax; cfg_rand_ready = rr;
        cfg_silent = silent; cfg_slow_leaf = slow; cfg_junk = junk; cfg_rand_start = rs;
        cfg_seed = $urandom();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: the walk covers leaves 0..min(report,CAP), cut short before a silent leaf.
    task automatic build_expect(output int last, output int m, output bit exp_err);
        m = (int'(cfg_word0[15:0]) > CAP) ? CAP : int'(cfg_word0[15:0]);
        exp_err = (cfg_silent >= 0) && (cfg_silent <= m);
        last = exp_err ? cfg_silent - 1 : m;
        exp_q.delete();
        for (int l = 0; l <= last; l++)
            for (int i = 0; i < 4; i++)
                exp_q.push_back({16'(l), 2'(i), leaf_word(l, i)});
    endtask

    task automatic run_walk(input string name);
        int last, m, n, d0;
        bit exp_err;
        build_expect(last, m, exp_err);
        words = 0; last_out_leaf = '1; hs_edge_silent = -1; d0 = done_cnt;
        kick = 1;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        check({name, "_started"}, busy, 1);
        check({name, "_err_clr"}, err_timeout, 0);
        n = 0;
        while (done_cnt == d0 && n < 6000) begin tick(); n++; end
        check({name, "_done_seen"}, done_cnt - d0, 1);
        if (exp_err) check({name, "_tmo_cycles"}, done_edge - hs_edge_silent, TMO + 1);
        repeat (3) tick();
        check({name, "_one_done"}, done_cnt - d0, 1);
        check({name, "_idle"}, busy, 0);
        check({name, "_words"}, words, 4 * (last + 1));
        check({name, "_q_empty"}, exp_q.size(), 0);
        check({name, "_err"}, err_timeout, exp_err);
        check({name, "_max"}, max_leaf, (cfg_silent == 0) ? 0 : m);
        if (last >= 0) check({name, "_last_leaf"}, last_out_leaf, last);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, {busy, done, err_timeout, req_valid, out_valid, out_idx}, 0);
        check({name, "_max"}, max_leaf, 0);
        check({name, "_req"}, {req_leaf, req_subleaf}, 0);
        check({name, "_out"}, {out_leaf, out_word}, 0);
        check({name, "_state"}, dbg_state, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, d0, last, m;
        bit exp_err;
        rst_n = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        set_cfg(32'hABCD_0005, 0, 0, 0, -1, -1, 0, 0);
        run_walk("normal");
        set_cfg(32'h0000_00FF, 0, 0, 0, -1, -1, 0, 0);
        run_walk("clamp");
        set_cfg(32'h1234_0000, 0, 0, 0, -1, -1, 0, 0);
        run_walk("zero_max");
        set_cfg(32'h0000_0005, 0, 0, 0, 2, -1, 0, 0);
        run_walk("timeout");
        set_cfg(32'h0000_0005, 0, 2, 0, -1, -1, 0, 0);
        run_walk("after_tmo");
        for (int k = 0; k < 3; k++) begin
            set_cfg(32'h0000_0005, 0, 10, 1, -1, -1, 0, 0);
            run_walk("backpressure");
        end
        set_cfg(32'h0000_0002, 0, 0, 0, -1, 1, 0, 0);
        run_walk("tmo_edge_rsp");
        set_cfg(32'h0000_0003, 0, 3, 1, -1, -1, 1, 1);
        run_walk("races");
        set_cfg(32'h0000_0001, 0, 0, 0, 0, -1, 0, 0);
        run_walk("silent_leaf0");

        // Reset in the middle of leaf 3 word 2.
        set_cfg(32'h0000_0005, 0, 1, 0, -1, -1, 0, 0);
        build_expect(last, m, exp_err);
        kick = 1;
        n = 0;
        while (!(out_valid && out_leaf == 16'd3 && out_idx == 2'd2) && n < 2000) begin tick(); n++; end
        check("rst_reach_l3i2", {out_valid, out_leaf, out_idx}, {1'b1, 16'd3, 2'd2});
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid_now");
        tick();
        check_outputs_zero("rst_mid_next");
        repeat (2) tick();
        rst_n = 1'b1;
        exp_q.delete();
        repeat (5) tick();
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_stays_idle", busy, 0);
        set_cfg(32'h0000_0005, 0, 1, 0, -1, -1, 0, 0);
        run_walk("replay");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound in case a bounded wait is itself broken.
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
